// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel encodings and the refill bridge state type.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } bridge_state_e;

endpackage

// File: rtl/icache_axi_read_bridge_if.sv
// AXI4 read-address and read-data channels between the refill bridge and the interconnect.
interface icache_axi_read_bridge_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/icache_axi_read_bridge.sv
// Turns an I$ line-refill request into one AXI4 INCR read burst and streams
// the beats back to the cache one word per cycle, flagging the final beat.
//
// state | meaning
// IDLE  | waiting for a refill request; inst_addr_ok follows inst_read_req
// ADDR  | AR channel presented, waiting for arready
// DATA  | accepting R beats until BURST_LEN have been taken
module icache_axi_read_bridge
   import axi_pkg::*;
#(
   parameter int          BURST_LEN  = 16,
   parameter logic [3:0]  AXI_ID     = 4'd0,
   parameter int          LINE_OFF_W = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inst_read_req,
   input  logic [31:0]              inst_addr_mmu,
   output logic                     inst_addr_ok,
   output logic                     mmu_valid,
   output logic [31:0]              inst_read_data,
   output logic                     mmu_last,
   output logic                     bus_err,
   icache_axi_read_bridge_if.master axi
);

   localparam int          BEAT_W    = $clog2(BURST_LEN);
   localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFF_W) - 32'd1);

   bridge_state_e     state_q, state_d;
   logic [31:0]       araddr_q, araddr_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              mmu_valid_q, mmu_valid_d;
   logic              mmu_last_q, mmu_last_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              bus_err_q, bus_err_d;

   logic beat_acc;
   logic last_beat;

   assign beat_acc  = axi.rvalid && (state_q == DATA);
   assign last_beat = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));

   assign inst_addr_ok   = (state_q == IDLE) && inst_read_req;
   assign mmu_valid      = mmu_valid_q;
   assign mmu_last       = mmu_last_q;
   assign inst_read_data = rd_data_q;
   assign bus_err        = bus_err_q;

   assign axi.arid    = AXI_ID;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = 8'(BURST_LEN - 1);
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arvalid = (state_q == ADDR);
   assign axi.rready  = (state_q == DATA);

   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      beat_cnt_d  = beat_cnt_q;
      mmu_valid_d = 1'b0;
      mmu_last_d  = 1'b0;
      rd_data_d   = rd_data_q;
      bus_err_d   = bus_err_q;

      case (state_q)
         IDLE: begin
            if (inst_read_req) begin
               araddr_d   = inst_addr_mmu & LINE_MASK;
               beat_cnt_d = '0;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            if (axi.arready) state_d = DATA;
         end
         DATA: begin
            if (beat_acc) begin
               mmu_valid_d = 1'b1;
               mmu_last_d  = last_beat;
               rd_data_d   = axi.rdata;
               beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
               // Termination is counted locally; a wrong rlast only raises the error flag.
               if ((axi.rresp != AXI_RESP_OKAY) || (axi.rlast != last_beat)) bus_err_d = 1'b1;
               if (last_beat) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         araddr_q    <= '0;
         beat_cnt_q  <= '0;
         mmu_valid_q <= 1'b0;
         mmu_last_q  <= 1'b0;
         rd_data_q   <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         araddr_q    <= araddr_d;
         beat_cnt_q  <= beat_cnt_d;
         mmu_valid_q <= mmu_valid_d;
         mmu_last_q  <= mmu_last_d;
         rd_data_q   <= rd_data_d;
         bus_err_q   <= bus_err_d;
      end
   end

endmodule

// File: doc/icache_axi_read_bridge.md
Name: icache_axi_read_bridge

Overview:
- Downstream neighbour of the instruction cache: converts its line-refill request into a single AXI4 INCR read burst.
- Returns the burst beats to the cache one word per cycle, flagging the final beat.
- Sits between the I$ and the system AXI interconnect; read-only, one outstanding burst at a time.

Parameters:
- BURST_LEN, 16, beats per line (32-bit words); must be a power of two, 2..16.
- AXI_ID, 4'd0, constant ARID driven on every burst.
- LINE_OFF_W, 6, byte-offset bits of a line; log2(BURST_LEN*4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_read_req  in  1  refill request from I$
- inst_addr_mmu  in  32  refill physical address from I$; low LINE_OFF_W bits ignored
- inst_addr_ok  out  1  request accepted (combinational)
- mmu_valid  out  1  inst_read_data holds a valid beat (registered)
- inst_read_data  out  32  beat data (registered)
- mmu_last  out  1  final beat of line; qualified by mmu_valid (registered)
- bus_err  out  1  sticky error: RRESP != OKAY or RLAST mismatch
- arid  out  4  equals AXI_ID
- araddr  out  32  line-aligned address
- arlen  out  8  BURST_LEN-1
- arsize  out  3  3'b010
- arburst  out  2  2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address ready
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  data ready

Behaviour:
- Reset: state=IDLE.
- Registered outputs clear on reset: mmu_valid=0, mmu_last=0, inst_read_data=0, bus_err=0, araddr=0.
- Combinational outputs with state=IDLE after reset: arvalid=0, rready=0, inst_addr_ok=0 unless inst_read_req=1.
- rst is system-wide; AXI slave resets simultaneously, so an abort mid-burst needs no drain.
- FSM IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - inst_addr_ok = inst_read_req (same cycle).
  - On inst_read_req, latch araddr = {inst_addr_mmu[31:LINE_OFF_W], zeros}, clear beat_cnt, go to ADDR.
- ADDR:
  - arvalid=1. araddr, arlen, arsize and arburst stay stable until handshake.
  - On arvalid&&arready, go to DATA. Earliest arvalid is the cycle after acceptance.
  - inst_addr_ok=0 in every state other than IDLE. New I$ requests wait; the I$ retries.
- DATA:
  - rready=1 every cycle.
  - On each rvalid&&rready, next cycle: mmu_valid=1, inst_read_data=rdata, mmu_last=(beat_cnt==BURST_LEN-1), and beat_cnt increments (log2(BURST_LEN) bits, wraps to 0).
  - If no beat is accepted, next cycle mmu_valid=0 and mmu_last=0. Gaps in rvalid propagate as gaps in mmu_valid.
  - When beat_cnt==BURST_LEN-1 is accepted, go to IDLE.
  - Earliest new inst_addr_ok is the same cycle mmu_last is presented.
- Latency:
  - Request to arvalid: 1 cycle.
  - Each R beat to mmu_valid: 1 cycle.
  - Minimum request-to-last: 1 + 1 (arready) + BURST_LEN cycles.
- Errors:
  - If rresp != 2'b00 on an accepted beat, set bus_err; data is still forwarded.
  - If rlast != (beat_cnt==BURST_LEN-1) on an accepted beat, set bus_err.
  - Burst termination follows beat_cnt, never rlast.
  - bus_err clears only on rst.
- mmu_last is never asserted without mmu_valid.
- Exactly BURST_LEN mmu_valid pulses per accepted request.

Decomposition:
- Package axi_pkg: AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY constants; typedef enum logic[1:0] {IDLE, ADDR, DATA} for the bridge FSM.
- No sub-module: FSM, beat counter and output register fit in one module.

Test Plan:
- Basic refill: req addr 0x1FC0_0044, arready=1 immediately, rvalid every cycle with rdata=i, rlast on i=15.
  - inst_addr_ok=1 in cycle 0; araddr=0x1FC0_0040, arlen=15, arsize=2, arburst=1.
  - 16 mmu_valid pulses, data 0..15; mmu_last only with data 15; bus_err=0.
- Address backpressure: arready low 5 cycles. arvalid held and araddr stable for all 6 cycles; no mmu_valid until R beats arrive.
- Data gaps: rvalid toggles 1,0,1,0... Each gap produces mmu_valid=0 one cycle later; still 16 beats; last is correct.
- Request during burst: inst_read_req held high throughout DATA. inst_addr_ok=0 until IDLE; the second burst's arvalid follows the cycle after acceptance.
- Error: beat 7 has rresp=2'b10; separately, rlast=1 on beat 3. bus_err rises one cycle after each; burst still completes 16 beats.
- Reset mid-burst: rst at beat 5. Next cycle mmu_valid=0, arvalid=0, rready=0, bus_err=0; a fresh request is accepted normally.
